// File: rtl/hp_sensor_ctrl_if.sv
// hp_sensor_ctrl_if: sensor-array and host-side signals of the Hogge-phase glitch-sensor controller
//   en, clr_flags, selftest_req : host controls (write-1-to-clear, request pulse)
//   sens_alarm                  : raw sensor alarms, asynchronous to the controller clock
//   sens_vcc, sens_glitch       : per-sensor supply enable and glitch-injection control
//   alarm_flags, selftest_fail, selftest_busy, selftest_done, irq : status back to the host
//   master = host/sensor side, slave = controller
interface hp_sensor_ctrl_if #(parameter int NSENS = 4);
  logic en;
  logic selftest_req;
  logic selftest_busy;
  logic selftest_done;
  logic irq;
  logic [NSENS-1:0] sens_alarm;
  logic [NSENS-1:0] sens_vcc;
  logic [NSENS-1:0] sens_glitch;
  logic [NSENS-1:0] clr_flags;
  logic [NSENS-1:0] alarm_flags;
  logic [NSENS-1:0] selftest_fail;
  modport master (
    output en, sens_alarm, clr_flags, selftest_req,
    input  sens_vcc, sens_glitch, alarm_flags, selftest_fail, selftest_busy, selftest_done, irq
  );
  modport slave (
    input  en, sens_alarm, clr_flags, selftest_req,
    output sens_vcc, sens_glitch, alarm_flags, selftest_fail, selftest_busy, selftest_done, irq
  );
endinterface

// File: rtl/hp_sensor_ctrl.sv
// hp_sensor_ctrl: power, debounce, sticky alarm flags and self-test for an array of glitch sensors
//   CK   : clock
//   RSTN : asynchronous active-low reset
//   bus  : hp_sensor_ctrl_if.slave (host controls, sensor supply/injection, status and irq)
module hp_sensor_ctrl #(
  parameter int NSENS      = 4,
  parameter int WARMUP     = 8,
  parameter int THRESH     = 2,
  parameter int ST_PERIOD  = 1024,
  parameter int GLITCH_LEN = 1,
  parameter int ST_WINDOW  = 6,
  parameter int BLANK      = 2
) (
  input logic CK,
  input logic RSTN,
  hp_sensor_ctrl_if.slave bus
);
  localparam int MX = (WARMUP > ST_WINDOW) ? ((WARMUP > BLANK) ? WARMUP : BLANK)
                                           : ((ST_WINDOW > BLANK) ? ST_WINDOW : BLANK);
  localparam int CW = $clog2(MX + 1);
  localparam int TW = $clog2(THRESH + 1);
  localparam int PW = (ST_PERIOD > 1) ? $clog2(ST_PERIOD) : 1;

  typedef enum logic [2:0] {
    S_OFF, S_WARMUP, S_MONITOR, S_INJECT, S_WAIT, S_CHECK, S_BLANK
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [PW-1:0]            per_q, per_d;
  logic [NSENS-1:0][TW-1:0] dcnt_q, dcnt_d;
  logic [NSENS-1:0]         sync_q, alarm_s_q;
  logic [NSENS-1:0]         seen_q, seen_d;
  logic [NSENS-1:0]         flags_q, flags_d;
  logic [NSENS-1:0]         fail_q, fail_d;
  logic [NSENS-1:0]         set;
  logic                     pend_q, pend_d;
  logic                     done_q, done_d;
  logic                     irq_q;
  logic                     start;

  always_comb begin
    start = state_q == S_MONITOR && bus.en &&
            (pend_q || bus.selftest_req || (ST_PERIOD != 0 && per_q == PW'(ST_PERIOD - 1)));
    state_d = state_q;
    case (state_q)
      S_OFF:     state_d = S_WARMUP;
      S_WARMUP:  if (cnt_q == CW'(WARMUP - 1)) state_d = S_MONITOR;
      S_MONITOR: if (start) state_d = S_INJECT;
      S_INJECT:  if (cnt_q == CW'(GLITCH_LEN - 1)) state_d = S_WAIT;
      S_WAIT:    if (cnt_q == CW'(ST_WINDOW - 1)) state_d = S_CHECK;
      S_CHECK:   state_d = (BLANK == 0) ? S_MONITOR : S_BLANK;
      S_BLANK:   if (cnt_q == CW'(BLANK - 1)) state_d = S_MONITOR;
      default:   state_d = S_OFF;
    endcase
    if (!bus.en) state_d = S_OFF;
    // The window count runs on from the first inject cycle through ST_WAIT, so it is
    // not restarted on the INJECT->WAIT step; every other state change restarts it.
    cnt_d = (state_d == S_OFF || state_d == S_MONITOR || (state_d != state_q && state_d != S_WAIT))
            ? '0 : cnt_q + 1'b1;
    per_d = (state_q == S_MONITOR && state_d == S_MONITOR) ? per_q + 1'b1 : '0;
    set = '0;
    dcnt_d = '0;
    for (int i = 0; i < NSENS; i++) begin
      dcnt_d[i] = (state_q == S_MONITOR && alarm_s_q[i])
                  ? ((dcnt_q[i] == TW'(THRESH)) ? dcnt_q[i] : dcnt_q[i] + 1'b1) : '0;
      set[i] = state_q == S_MONITOR && dcnt_d[i] == TW'(THRESH);
    end
    // A set in the same cycle as its clear wins.
    flags_d = (flags_q & ~bus.clr_flags) | set;
    seen_d = (state_q == S_MONITOR) ? '0 : (state_q == S_WAIT) ? (seen_q | alarm_s_q) : seen_q;
    fail_d = start ? '0 : (state_q == S_CHECK && bus.en) ? ~seen_q : fail_q;
    done_d = state_q == S_CHECK && bus.en;
    pend_d = start ? 1'b0
           : ((state_q == S_OFF || state_q == S_WARMUP) && bus.selftest_req) ? 1'b1 : pend_q;
  end

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q   <= S_OFF;
      cnt_q     <= '0;
      per_q     <= '0;
      dcnt_q    <= '0;
      sync_q    <= '0;
      alarm_s_q <= '0;
      seen_q    <= '0;
      flags_q   <= '0;
      fail_q    <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      per_q     <= per_d;
      dcnt_q    <= dcnt_d;
      sync_q    <= bus.sens_alarm;
      alarm_s_q <= sync_q;
      seen_q    <= seen_d;
      flags_q   <= flags_d;
      fail_q    <= fail_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
      irq_q     <= |flags_q || |fail_q;
    end
  end

  assign bus.sens_vcc      = {NSENS{state_q != S_OFF}};
  assign bus.sens_glitch   = {NSENS{state_q == S_INJECT}};
  assign bus.alarm_flags   = flags_q;
  assign bus.selftest_fail = fail_q;
  assign bus.selftest_busy = state_q inside {S_INJECT, S_WAIT, S_CHECK, S_BLANK};
  assign bus.selftest_done = done_q;
  assign bus.irq           = irq_q;
endmodule

// File: tb/tb_hp_sensor_ctrl.sv
// tb_hp_sensor_ctrl: directed and randomized checks of hp_sensor_ctrl against a timeline model
module tb_hp_sensor_ctrl;
  localparam int N   = 4;
  localparam int WU  = 8;
  localparam int TH  = 2;
  localparam int PER = 16;
  localparam int GL  = 1;
  localparam int WIN = 6;
  localparam int BL  = 2;
  localparam int TL  = WIN + 1 + BL;

  logic CK = 1'b0;
  logic RSTN = 1'b0;
  logic [N-1:0] ext = '0;
  logic [N-1:0] healthy = '1;
  int npass = 0;
  int ntot = 0;

  hp_sensor_ctrl_if #(.NSENS(N)) bus ();

  hp_sensor_ctrl #(
    .NSENS(N), .WARMUP(WU), .THRESH(TH), .ST_PERIOD(PER),
    .GLITCH_LEN(GL), .ST_WINDOW(WIN), .BLANK(BL)
  ) dut (
    .CK(CK),
    .RSTN(RSTN),
    .bus(bus)
  );

  always #5 CK = ~CK;

  // Healthy sensors alarm while their glitch input is driven; ext models real glitch events.
  assign bus.sens_alarm = ext | (bus.sens_glitch & healthy);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Timeline model: powered flag, age since power-up, time index within a self-test
  // (-1 when not testing), monitor cycles since last test, and alarm run lengths.
  bit         m_on, m_pend, m_done, m_irq;
  int         m_age, m_per;
  int         m_tt = -1;
  int         m_rl [N];
  bit [N-1:0] m_h1, m_h2, m_seen, m_flags, m_fail;

  always @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      m_on = 0; m_pend = 0; m_done = 0; m_irq = 0;
      m_age = 0; m_per = 0; m_tt = -1;
      m_h1 = '0; m_h2 = '0; m_seen = '0; m_flags = '0; m_fail = '0;
      foreach (m_rl[i]) m_rl[i] = 0;
    end else begin
      bit [N-1:0] raw, set;
      bit warm, mon, start;
      raw   = ext | ({N{m_on && m_tt >= 0 && m_tt < GL}} & healthy);
      warm  = m_on && m_age < WU;
      mon   = m_on && !warm && m_tt < 0;
      start = mon && bus.en && (m_pend || bus.selftest_req || m_per == PER - 1);
      set = '0;
      for (int i = 0; i < N; i++) begin
        m_rl[i] = (mon && m_h2[i]) ? m_rl[i] + 1 : 0;
        if (m_rl[i] >= TH) set[i] = 1'b1;
      end
      m_irq   = |m_flags || |m_fail;
      m_flags = (m_flags & ~bus.clr_flags) | set;
      m_done  = m_tt == WIN && bus.en;
      if (m_tt >= GL && m_tt < WIN) m_seen |= m_h2;
      if (m_done) m_fail = ~m_seen;
      if (!m_on || warm) m_pend |= bus.selftest_req;
      if (!bus.en) begin
        m_on = 0; m_tt = -1; m_per = 0;
      end else if (!m_on) begin
        m_on = 1; m_age = 0;
      end else if (warm) m_age++;
      else if (start) begin
        m_tt = 0; m_seen = '0; m_fail = '0; m_pend = 0; m_per = 0;
      end else if (mon) m_per++;
      else begin
        m_tt++;
        if (m_tt == TL) begin m_tt = -1; m_per = 0; end
      end
      m_h2 = m_h1;
      m_h1 = raw;
    end
  end

  always @(negedge CK) begin
    chk("vcc", bus.sens_vcc, {N{m_on}});
    chk("glitch", bus.sens_glitch, {N{m_on && m_tt >= 0 && m_tt < GL}});
    chk("flags", bus.alarm_flags, m_flags);
    chk("fail", bus.selftest_fail, m_fail);
    chk("busy", bus.selftest_busy, m_tt >= 0);
    chk("done", bus.selftest_done, m_done);
    chk("irq", bus.irq, m_irq);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CK);
  endtask

  // sel: 0 = selftest_done, 1 = sens_glitch, 2 = selftest_busy
  task automatic wait_on(input string tag, input int sel, input int lim);
    bit hit = 0;
    for (int i = 0; i < lim && !hit; i++) begin
      @(negedge CK);
      hit = (sel == 0) ? bus.selftest_done : (sel == 1) ? bus.sens_glitch[0] : bus.selftest_busy;
    end
    chk(tag, hit, 1);
  endtask

  initial begin
    bus.en = 0; bus.clr_flags = '0; bus.selftest_req = 0;
    cyc(3);
    chk("rst_vcc", bus.sens_vcc, 0);
    chk("rst_irq", bus.irq, 0);
    RSTN = 1;
    cyc(2);
    bus.en = 1;
    cyc(1);
    chk("vcc_on", bus.sens_vcc, 4'hF);
    cyc(8);
    chk("mon_flags", bus.alarm_flags, 0);
    chk("mon_busy", bus.selftest_busy, 0);
    ext[2] = 1; cyc(2); ext[2] = 0; cyc(2);
    chk("flag2_set", bus.alarm_flags, 4'b0100);
    cyc(1);
    chk("irq_set", bus.irq, 1);
    ext[1] = 1; cyc(1); ext[1] = 0; cyc(5);
    chk("pulse_ignored", bus.alarm_flags, 4'b0100);
    bus.clr_flags = 4'b0100; cyc(1); bus.clr_flags = '0;
    chk("flag2_clr", bus.alarm_flags, 0);
    cyc(1);
    chk("irq_clr", bus.irq, 0);
    healthy = 4'b1011;
    bus.selftest_req = 1; cyc(1); bus.selftest_req = 0;
    wait_on("st_done1", 0, 60);
    wait_on("st_done2", 0, 60);
    chk("st_fail2", bus.selftest_fail, 4'b0100);
    chk("st_noflags", bus.alarm_flags, 0);
    cyc(1);
    chk("st_irq", bus.irq, 1);
    healthy = '1;
    wait_on("per_done", 0, 60);
    chk("per_fail0", bus.selftest_fail, 0);
    cyc(40);
    wait_on("abort_inj", 1, 60);
    cyc(2);
    bus.en = 0;
    cyc(1);
    chk("abort_vcc", bus.sens_vcc, 0);
    chk("abort_busy", bus.selftest_busy, 0);
    bus.selftest_req = 1; cyc(1); bus.selftest_req = 0;
    cyc(2);
    bus.en = 1;
    wait_on("pend_run", 1, WU + 4);
    wait_on("pend_done", 0, 20);
    cyc(3);
    ext[0] = 1; cyc(3);
    bus.clr_flags = 4'b0001; cyc(1); bus.clr_flags = '0;
    chk("set_wins", bus.alarm_flags[0], 1);
    ext[0] = 0; cyc(3);
    bus.clr_flags = 4'b0001; cyc(1); bus.clr_flags = '0;
    wait_on("rst_busy", 2, 40);
    cyc(1);
    #2 RSTN = 0;
    #1;
    chk("arst_vcc", bus.sens_vcc, 0);
    chk("arst_busy", bus.selftest_busy, 0);
    chk("arst_glitch", bus.sens_glitch, 0);
    @(negedge CK) RSTN = 1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge CK);
      if ($urandom_range(0, 3) == 0) ext = N'($urandom) & N'($urandom);
      bus.clr_flags = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      bus.selftest_req = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 199) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 99) == 0) healthy = N'($urandom);
    end
    cyc(2);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/hp_sensor_ctrl.md
Name: hp_sensor_ctrl

Overview:
Controller for an array of NSENS Hogge-phase glitch sensors (ring-oscillator modulator plus phase detector per sensor). It powers the sensors up and holds them through warm-up, debounces and latches their alarm outputs into sticky flags, and raises an interrupt. It also runs self-tests, periodic or on request, by injecting a glitch into every sensor and checking that each one alarms. It sits between the sensor macros and the host/security register block.

Parameters:
NSENS, 4, number of sensor instances controlled
WARMUP, 8, CK cycles after power-up during which alarms are ignored (>=1)
THRESH, 2, consecutive synchronised alarm cycles needed to set a flag (>=1)
ST_PERIOD, 1024, MONITOR cycles between automatic self-tests; 0 disables periodic self-test
GLITCH_LEN, 1, cycles sens_glitch is held high during injection (>=1)
ST_WINDOW, 6, cycles after injection start in which each sensor must alarm (>GLITCH_LEN+2)
BLANK, 2, cycles of alarm blanking after self-test

Ports:
CK  in  1  clock
RSTN  in  1  asynchronous active-low reset
en  in  1  enable; 1 = sensors powered and monitored
sens_alarm  in  NSENS  raw sensor Alarm outputs (asynchronous to CK; synchronise)
sens_vcc  out  NSENS  per-sensor modulator supply/enable
sens_glitch  out  NSENS  per-sensor glitch-injection control
clr_flags  in  NSENS  write-1-to-clear for alarm_flags (single-cycle pulses)
selftest_req  in  1  request a self-test (pulse)
alarm_flags  out  NSENS  sticky per-sensor alarm flags
selftest_fail  out  NSENS  per-sensor failure from last self-test
selftest_busy  out  1  high while in ST_INJECT/ST_WAIT/ST_CHECK/ST_BLANK
selftest_done  out  1  one-cycle pulse when a self-test result is written
irq  out  1  registered: |alarm_flags | |selftest_fail

Behaviour:
- Reset: state OFF; all outputs 0; counters, sync flops and pending request cleared.
- sens_alarm passes a 2-flop synchroniser (alarm_s); all decisions use alarm_s. Raw-to-flag latency is 2+THRESH cycles.
- FSM states: OFF, WARMUP, MONITOR, ST_INJECT, ST_WAIT, ST_CHECK, ST_BLANK.
- OFF: sens_vcc=0, sens_glitch=0. en=1 moves to WARMUP.
- WARMUP: sens_vcc all 1; warm-up counter counts WARMUP cycles; debounce counters held at 0. Then MONITOR.
- MONITOR: a per-sensor counter increments while alarm_s=1 and resets to 0 when alarm_s=0, saturating at THRESH. Reaching THRESH sets the alarm_flags bit. The period timer increments each cycle.
- Self-test entry: a self-test starts from MONITOR when (ST_PERIOD!=0 and the period timer reaches ST_PERIOD-1) or when a request is pending. On entry: selftest_fail cleared, seen[] cleared, pending cleared, period timer reset.
- selftest_req handling:
  - Received in OFF or WARMUP: latched as pending.
  - Received during a self-test: dropped.
- ST_INJECT: sens_glitch all 1 for GLITCH_LEN cycles, then ST_WAIT.
- ST_WAIT: runs until ST_WINDOW cycles have elapsed since the first inject cycle. seen[i] is set on any cycle with alarm_s[i]=1.
- ST_CHECK (1 cycle): selftest_fail <= ~seen; selftest_done=1; then ST_BLANK.
- ST_BLANK: BLANK cycles; debounce counters held at 0; then MONITOR.
- From ST_INJECT through ST_BLANK, alarms never set alarm_flags. sens_glitch is 0 outside ST_INJECT.
- en=0 in any state: next cycle OFF, with sens_vcc=0, sens_glitch=0, selftest_busy=0, counters cleared. An aborted self-test leaves selftest_fail unchanged and gives no done pulse. alarm_flags and selftest_fail are retained.
- Simultaneous set and clr_flags on the same bit: set wins, so the flag stays 1.
- irq is registered and clears one cycle after all flags and fails are clear.
- RSTN assertion at any time: immediate return to reset values.

Test Plan:
- Reset, en=1, sens_alarm=0: sens_vcc goes 4'hF one cycle after en; MONITOR after 8 cycles; alarm_flags=0, irq=0.
- In MONITOR, sens_alarm[2] high 2 cycles: alarm_flags=4'b0100 at cycle 4 after the raw rise, irq the next cycle. A 1-cycle pulse on sens_alarm[1] leaves its flag at 0. clr_flags[2] clears the flag, and irq drops the following cycle.
- selftest_req with a sensor model that echoes glitch to alarm for sensors 0,1,3 only: sens_glitch=4'hF for 1 cycle; selftest_done pulses; selftest_fail=4'b0100; alarm_flags unchanged (0); irq=1.
- ST_PERIOD=16, all sensors healthy: self-tests repeat every 16 MONITOR cycles plus test duration; selftest_fail stays 0; no flags set.
- en dropped during ST_WAIT: next cycle sens_vcc=0, sens_glitch=0, busy=0, no done pulse; re-enable gives WARMUP again. A selftest_req issued during OFF runs right after warm-up.
- clr_flags[0] and a threshold-reaching alarm on sensor 0 in the same cycle: alarm_flags[0]=1. RSTN low mid-test: all outputs 0 asynchronously.
